// File: rtl/note_sequencer.sv
// note_sequencer
//   Walks a song ROM entry by entry and feeds note_player: for each entry it presents
//   note_to_load/weight with a one-cycle load_new_note strobe, then holds the note for
//   `duration` beat pulses before fetching the next entry.
//
//   Optional feature macro: SONG_LOOP_EN
//     defined   - end marker or expiry at the last index restarts the song at index 0;
//                 DONE is never entered and song_done stays 0.
//     undefined - the song stops in DONE.
//
// Ports
//   clk            system clock
//   reset          synchronous, active-high
//   play           1 = run, 0 = pause
//   restart        1-cycle pulse, restart the current song at index 0
//   song_sel       selected song
//   beat           1-cycle tick from beat_generator
//   rom_addr       {song, idx} address to the song ROM
//   rom_data       {note[13:8], duration[7:2], weight[1:0]}, valid ROM_LAT cycles after rom_addr
//   note_to_load   note to note_player, 0 = rest (registered)
//   weight         harmonic weight to note_player (registered)
//   load_new_note  1-cycle load strobe (registered, high the cycle after LOAD)
//   play_enable    registered copy of play, low in IDLE/DONE
//   song_done      high while in DONE
//
// state | meaning
// IDLE  | after reset, waiting for play
// FETCH | rom_addr presented for the current idx
// WAIT  | ROM_LAT cycles of ROM latency, then rom_data captured
// LOAD  | captured entry pushed to the outputs, hold counter loaded
// HOLD  | counting beats down to the end of the note
// DONE  | end of song, outputs parked until restart/song change/reset
module note_sequencer #(
   parameter int IDX_W   = 5,
   parameter int SONG_W  = 2,
   parameter int ROM_LAT = 1
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    play,
   input  logic                    restart,
   input  logic [SONG_W-1:0]       song_sel,
   input  logic                    beat,
   output logic [SONG_W+IDX_W-1:0] rom_addr,
   input  logic [13:0]             rom_data,
   output logic [5:0]              note_to_load,
   output logic [1:0]              weight,
   output logic                    load_new_note,
   output logic                    play_enable,
   output logic                    song_done
);

   localparam int WCNT_W = (ROM_LAT > 1) ? $clog2(ROM_LAT) : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_WAIT,
      S_LOAD,
      S_HOLD,
      S_DONE
   } state_t;

   state_t            state_q, state_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [5:0]        cnt_q, cnt_d;
   logic [WCNT_W-1:0] wcnt_q, wcnt_d;
   logic              got_q, got_d;
   logic [13:0]       data_q, data_d;
   logic [SONG_W-1:0] song_q;
   logic [5:0]        note_q, note_d;
   logic [1:0]        weight_q, weight_d;
   logic              load_q, load_d;
   logic              pe_q;
   logic              jump;
   logic              last_idx;
   logic [5:0]        dur_now;

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      cnt_d    = cnt_q;
      wcnt_d   = wcnt_q;
      got_d    = got_q;
      data_d   = data_q;
      note_d   = note_q;
      weight_d = weight_q;
      load_d   = 1'b0;
      last_idx = (idx_q == '1);
      // restart or a new song abandons whatever is in flight, including a pending expiry
      jump     = (state_q != S_IDLE) && (restart || (song_sel != song_q));
      // duration seen either from the capture register or from the word landing this cycle
      dur_now  = got_q ? data_q[7:2] : rom_data[7:2];

      if (jump) begin
         idx_d   = '0;
         state_d = S_FETCH;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (play) state_d = S_FETCH;
            end
            S_FETCH: begin
               wcnt_d  = WCNT_W'(ROM_LAT - 1);
               got_d   = 1'b0;
               state_d = S_WAIT;
            end
            S_WAIT: begin
               // the read completes even while paused; only the advance waits for play
               if (!got_q) begin
                  if (wcnt_q != '0) begin
                     wcnt_d = wcnt_q - WCNT_W'(1);
                  end else begin
                     data_d = rom_data;
                     got_d  = 1'b1;
                  end
               end
               if ((got_q || (wcnt_q == '0)) && play) begin
                  if (dur_now == 6'd0) begin
`ifdef SONG_LOOP_EN
                     idx_d   = '0;
                     state_d = S_FETCH;
`else
                     note_d  = '0;
                     state_d = S_DONE;
`endif
                  end else begin
                     state_d = S_LOAD;
                  end
               end
            end
            S_LOAD: begin
               if (play) begin
                  load_d   = 1'b1;
                  note_d   = data_q[13:8];
                  weight_d = data_q[1:0];
                  cnt_d    = data_q[7:2];
                  state_d  = S_HOLD;
               end
            end
            S_HOLD: begin
               if (beat && play) begin
                  cnt_d = cnt_q - 6'd1;
                  if (cnt_q == 6'd1) begin
`ifdef SONG_LOOP_EN
                     idx_d   = last_idx ? '0 : idx_q + IDX_W'(1);
                     state_d = S_FETCH;
`else
                     if (last_idx) begin
                        note_d  = '0;
                        state_d = S_DONE;
                     end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = S_FETCH;
                     end
`endif
                  end
               end
            end
            S_DONE: begin
               state_d = S_DONE;
            end
            default: begin
               state_d = S_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= S_IDLE;
         idx_q    <= '0;
         cnt_q    <= '0;
         wcnt_q   <= '0;
         got_q    <= 1'b0;
         data_q   <= '0;
         song_q   <= '0;
         note_q   <= '0;
         weight_q <= '0;
         load_q   <= 1'b0;
         pe_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         cnt_q    <= cnt_d;
         wcnt_q   <= wcnt_d;
         got_q    <= got_d;
         data_q   <= data_d;
         song_q   <= song_sel;
         note_q   <= note_d;
         weight_q <= weight_d;
         load_q   <= load_d;
         pe_q     <= play && (state_d != S_IDLE) && (state_d != S_DONE);
      end
   end

   assign rom_addr      = {song_q, idx_q};
   assign note_to_load  = note_q;
   assign weight        = weight_q;
   assign load_new_note = load_q;
   assign play_enable   = pe_q;
   assign song_done     = (state_q == S_DONE);

endmodule

// File: tb/tb_note_sequencer.sv
module tb_note_sequencer;

   localparam int IDX_W   = 5;
   localparam int SONG_W  = 2;
   localparam int ROM_LAT = 2;

   logic                    clk = 1'b0;
   logic                    reset;
   logic                    play;
   logic                    restart;
   logic [SONG_W-1:0]       song_sel;
   logic                    beat;
   logic [SONG_W+IDX_W-1:0] rom_addr;
   logic [13:0]             rom_data;
   logic [5:0]              note_to_load;
   logic [1:0]              weight;
   logic                    load_new_note;
   logic                    play_enable;
   logic                    song_done;

   int n_assert = 0;
   int n_fail   = 0;
   int cyc      = 0;

   typedef struct {
      logic [5:0] note;
      logic [1:0] w;
      int         at;
   } exp_t;
   exp_t exp_q[$];

   logic [13:0] rom [0:127];
   logic [13:0] rom_pipe [ROM_LAT];

   note_sequencer #(
      .IDX_W   (IDX_W),
      .SONG_W  (SONG_W),
      .ROM_LAT (ROM_LAT)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .play          (play),
      .restart       (restart),
      .song_sel      (song_sel),
      .beat          (beat),
      .rom_addr      (rom_addr),
      .rom_data      (rom_data),
      .note_to_load  (note_to_load),
      .weight        (weight),
      .load_new_note (load_new_note),
      .play_enable   (play_enable),
      .song_done     (song_done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // song ROM with ROM_LAT cycles of read latency
   always @(posedge clk) begin
      rom_pipe[0] <= rom[rom_addr];
      for (int i = 1; i < ROM_LAT; i++) rom_pipe[i] <= rom_pipe[i-1];
   end
   assign rom_data = rom_pipe[ROM_LAT-1];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   // scoreboard: every strobe must match the oldest expected entry, including its cycle
   always @(negedge clk) begin
      exp_t e;
      if (load_new_note === 1'b1) begin
         n_assert++;
         assert (exp_q.size() != 0) else begin
            n_fail++;
            $error("FAIL strobe_unexpected: observed strobe note %0d at cycle %0d, expected none",
                   note_to_load, cyc);
         end
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("strobe_note", 32'(note_to_load), 32'(e.note));
            chk("strobe_weight", 32'(weight), 32'(e.w));
            chk("strobe_cycle", cyc, e.at);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic run_to(input int c);
      while (cyc < c) step();
   endtask

   task automatic beat_at(input int c);
      run_to(c);
      beat = 1'b1;
      step();
      beat = 1'b0;
   endtask

   task automatic push(input logic [5:0] n, input logic [1:0] w, input int at);
      exp_t e;
      e.note = n;
      e.w    = w;
      e.at   = at;
      exp_q.push_back(e);
   endtask

   task automatic chk_idle(input string p);
      chk({p, "_note"}, 32'(note_to_load), 0);
      chk({p, "_weight"}, 32'(weight), 0);
      chk({p, "_load"}, 32'(load_new_note), 0);
      chk({p, "_play_en"}, 32'(play_enable), 0);
      chk({p, "_done"}, 32'(song_done), 0);
      chk({p, "_addr"}, 32'(rom_addr), 0);
   endtask

   initial begin
      reset    = 1'b1;
      play     = 1'b0;
      restart  = 1'b0;
      song_sel = '0;
      beat     = 1'b0;
      for (int i = 0; i < 128; i++) rom[i] = '0;
`ifdef SONG_LOOP_EN
      for (int i = 0; i < 4; i++) rom[i] = {6'(i + 1), 6'd1, 2'(3 - i)};
      rom[4] = '0;

      repeat (3) step();
      chk_idle("reset");
      reset = 1'b0;
      play  = 1'b1;
      beat  = 1'b1;
      for (int i = 0; i < 4; i++) push(6'(i + 1), 2'(3 - i), 8 + 5 * i);
      push(6'd1, 2'd3, 31);
      run_to(26);
      chk("loop_marker_addr", 32'(rom_addr), 4);
      chk("loop_done_low", 32'(song_done), 0);
      step();
      chk("loop_wrap_addr", 32'(rom_addr), 0);
      chk("loop_wrap_done_low", 32'(song_done), 0);
      run_to(30);
      beat = 1'b0;
      run_to(32);
      chk("loop_hold_note", 32'(note_to_load), 1);
      chk("loop_hold_weight", 32'(weight), 3);
      reset = 1'b1;
      step();
      chk_idle("loop_reset_hold");
`else
      rom[0]  = {6'd1, 6'd2, 2'd0};
      rom[1]  = {6'd5, 6'd3, 2'd2};
      rom[2]  = {6'd9, 6'd6, 2'd1};
      rom[32] = {6'd3, 6'd1, 2'd1};
      rom[33] = {6'd4, 6'd1, 2'd3};
      rom[64] = {6'd17, 6'd2, 2'd2};
      for (int i = 0; i < 32; i++) rom[96 + i] = {6'(i + 1), 6'd1, 2'(i)};

      // reset, then first fetch and strobe latency
      repeat (3) step();
      chk_idle("reset");
      reset = 1'b0;
      play  = 1'b1;
      push(6'd1, 2'd0, 8);
      step();
      chk("fetch_addr", 32'(rom_addr), 0);
      chk("play_en_run", 32'(play_enable), 1);
      beat_at(9);
      beat_at(11);

      // duration 3, beat during LOAD ignored
      push(6'd5, 2'd2, 16);
      beat_at(15);
      beat_at(17);
      beat_at(19);
      run_to(21);
      chk("dur3_not_yet", 32'(rom_addr), 1);
      beat = 1'b1;
      step();
      beat = 1'b0;
      chk("dur3_fetch", 32'(rom_addr), 2);

      // pause mid-hold
      push(6'd9, 2'd1, 26);
      beat_at(27);
      beat_at(29);
      play = 1'b0;
      step();
      chk("pause_play_en", 32'(play_enable), 0);
      for (int c = 31; c <= 39; c += 2) beat_at(c);
      chk("pause_addr", 32'(rom_addr), 2);
      chk("pause_play_en_held", 32'(play_enable), 0);
      run_to(41);
      play = 1'b1;
      step();
      chk("resume_play_en", 32'(play_enable), 1);
      beat_at(42);
      beat_at(44);
      beat_at(46);
      run_to(48);
      chk("resume_not_yet", 32'(rom_addr), 2);
      beat = 1'b1;
      step();
      beat = 1'b0;
      chk("resume_fetch", 32'(rom_addr), 3);

      // end marker in song 0
      run_to(52);
      chk("end0_done", 32'(song_done), 1);
      chk("end0_note", 32'(note_to_load), 0);
      chk("end0_play_en", 32'(play_enable), 0);

      // song 1 by song change from DONE, end marker at entry 2, then restart
      run_to(53);
      song_sel = 2'd1;
      push(6'd3, 2'd1, 58);
      step();
      chk("song1_addr", 32'(rom_addr), 32);
      chk("song1_done_low", 32'(song_done), 0);
      push(6'd4, 2'd3, 64);
      beat_at(59);
      beat_at(65);
      run_to(69);
      chk("end1_done", 32'(song_done), 1);
      chk("end1_note", 32'(note_to_load), 0);
      chk("end1_addr", 32'(rom_addr), 34);
      run_to(70);
      restart = 1'b1;
      push(6'd3, 2'd1, 75);
      step();
      restart = 1'b0;
      chk("restart_addr", 32'(rom_addr), 32);
      chk("restart_done_low", 32'(song_done), 0);

      // song change 0 -> 2 while a read is in flight
      run_to(76);
      song_sel = 2'd0;
      step();
      chk("song0_addr", 32'(rom_addr), 0);
      run_to(78);
      song_sel = 2'd2;
      push(6'd17, 2'd2, 83);
      step();
      chk("song2_addr", 32'(rom_addr), 64);

      // restart coincident with hold expiry
      beat_at(84);
      run_to(86);
      beat    = 1'b1;
      restart = 1'b1;
      push(6'd17, 2'd2, 91);
      step();
      beat    = 1'b0;
      restart = 1'b0;
      chk("restart_wins_addr", 32'(rom_addr), 64);

      // song 3: all 32 entries, expiry at the last index stops in DONE
      run_to(92);
      song_sel = 2'd3;
      beat     = 1'b1;
      for (int i = 0; i < 32; i++) push(6'(i + 1), 2'(i), 97 + 5 * i);
      run_to(252);
      chk("last_idx_not_done", 32'(song_done), 0);
      step();
      chk("last_idx_done", 32'(song_done), 1);
      chk("last_idx_note", 32'(note_to_load), 0);
      chk("last_idx_addr", 32'(rom_addr), 127);
      run_to(260);
      chk("last_idx_stays_done", 32'(song_done), 1);
      chk("sb_empty_after_wrap", exp_q.size(), 0);

      // reset mid-hold
      song_sel = 2'd1;
      beat     = 1'b0;
      push(6'd3, 2'd1, 265);
      run_to(266);
      chk("hold_note_before_reset", 32'(note_to_load), 3);
      chk("hold_weight_before_reset", 32'(weight), 1);
      reset = 1'b1;
      step();
      chk_idle("reset_hold");
`endif
      reset = 1'b0;
      play  = 1'b0;
      repeat (3) step();
      chk("sb_drained", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
